// File: rtl/bob_except_retire_scan_pkg.sv
// Shared constants, scan-state encoding and head arithmetic for the bob
// exception-store read-side scanner.
package bob_except_retire_scan_pkg;

  localparam int BOB_ROWS     = 48;
  localparam int BOB_COLS     = 10;
  localparam int EXC_FLAG_BIT = 0;
  localparam int EXC_WIDTH    = 16;
  localparam int ROW_AW       = 6;
  localparam int SLOT_W       = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EVAL   = 2'd1,
    REPORT = 2'd2,
    HALT   = 2'd3
  } scan_state_e;

  // Head pointer advance; the store has a non-power-of-two row count.
  function automatic logic [ROW_AW-1:0] head_inc(input logic [ROW_AW-1:0] h);
    if (h == ROW_AW'(BOB_ROWS - 1)) begin
      return '0;
    end
    return h + ROW_AW'(1);
  endfunction

endpackage

// File: rtl/bob_except_retire_scan_prienc.sv
// Lowest-set-bit encoder over one row's slot vector.
module bob_except_retire_scan_prienc
  import bob_except_retire_scan_pkg::*;
(
  input  logic [BOB_COLS-1:0] vec,
  output logic                found,
  output logic [SLOT_W-1:0]   idx
);

  // Scan from the top down so the last write is the lowest set bit.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = BOB_COLS - 1; k >= 0; k--) begin
      if (vec[k]) begin
        found = 1'b1;
        idx   = SLOT_W'(k);
      end
    end
  end

endmodule

// File: rtl/bob_except_retire_scan.sv
// Read-side sequencer: accepts one completed row, reads it from the store,
// retires the slots older than the first flagged one and reports that fault.
module bob_except_retire_scan
  import bob_except_retire_scan_pkg::*;
#(
  parameter int DATA_WIDTH = EXC_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           row_valid,
  input  logic [BOB_COLS-1:0]            row_mask,
  output logic                           row_ready,
  output logic                           ram_read_step,
  output logic [ROW_AW-1:0]              ram_read_addr,
  input  logic [BOB_COLS*DATA_WIDTH-1:0] ram_read_data,
  output logic [ROW_AW-1:0]              head,
  output logic                           ret_valid,
  output logic [ROW_AW-1:0]              ret_row,
  output logic [SLOT_W-1:0]              ret_count,
  output logic                           exc_valid,
  output logic [ROW_AW-1:0]              exc_row,
  output logic [SLOT_W-1:0]              exc_slot,
  output logic [DATA_WIDTH-1:0]          exc_data,
  input  logic                           exc_ack,
  output logic [1:0]                     scan_state
);

  // Handshake: a row transfers on a cycle where row_valid && row_ready &&
  // !flush; the producer holds row_mask stable while row_valid is high and
  // row_ready is low. exc_valid is held until a cycle with exc_ack in REPORT.

  scan_state_e state, state_nxt;

  logic [BOB_COLS-1:0]   mask_q;
  logic [DATA_WIDTH-1:0] words [BOB_COLS];
  logic [BOB_COLS-1:0]   flags;
  logic [BOB_COLS-1:0]   hit;
  logic                  hit_found;
  logic [SLOT_W-1:0]     hit_idx;
  logic [SLOT_W-1:0]     pop;

  always_comb begin
    for (int k = 0; k < BOB_COLS; k++) begin
      words[k] = ram_read_data[k*DATA_WIDTH +: DATA_WIDTH];
      flags[k] = words[k][EXC_FLAG_BIT];
    end
  end

  // Unoccupied slots can carry stale flags; mask them out before encoding.
  assign hit = mask_q & flags;

  bob_except_retire_scan_prienc u_prienc (
    .vec   (hit),
    .found (hit_found),
    .idx   (hit_idx)
  );

  always_comb begin
    pop = '0;
    for (int k = 0; k < BOB_COLS; k++) begin
      pop = pop + {{(SLOT_W-1){1'b0}}, mask_q[k]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    row_ready     = 1'b0;
    ram_read_step = 1'b0;
    case (state)
      IDLE: begin
        row_ready = 1'b1;
        if (row_valid) begin
          ram_read_step = 1'b1;
          state_nxt     = EVAL;
        end
      end
      EVAL: begin
        state_nxt = hit_found ? REPORT : IDLE;
      end
      REPORT: begin
        if (exc_ack) begin
          state_nxt = HALT;
        end
      end
      HALT: begin
        state_nxt = HALT;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    // Flush wins over everything, including a row being offered this cycle.
    if (flush) begin
      state_nxt     = IDLE;
      ram_read_step = 1'b0;
    end
  end

  assign ram_read_addr = head;
  assign scan_state    = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head      <= '0;
      mask_q    <= '0;
      ret_valid <= 1'b0;
      ret_row   <= '0;
      ret_count <= '0;
      exc_valid <= 1'b0;
      exc_row   <= '0;
      exc_slot  <= '0;
      exc_data  <= '0;
    end else begin
      ret_valid <= 1'b0;
      if (flush) begin
        head      <= '0;
        exc_valid <= 1'b0;
      end else begin
        if (ram_read_step) begin
          mask_q <= row_mask;
        end
        if (state == EVAL) begin
          ret_valid <= 1'b1;
          ret_row   <= head;
          if (hit_found) begin
            // Slots below the fault retire; head stays on the faulting row.
            ret_count <= hit_idx;
            exc_valid <= 1'b1;
            exc_row   <= head;
            exc_slot  <= hit_idx;
            exc_data  <= words[hit_idx];
          end else begin
            ret_count <= pop;
            head      <= head_inc(head);
          end
        end
        if (state == REPORT && exc_ack) begin
          exc_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_bob_except_retire_scan.sv
// Directed bench for bob_except_retire_scan with a registered-read store model
// and a retire scoreboard.
module tb_bob_except_retire_scan;

  localparam int W = 16;

  logic            clk;
  logic            rst;
  logic            flush;
  logic            row_valid;
  logic [9:0]      row_mask;
  logic            row_ready;
  logic            ram_read_step;
  logic [5:0]      ram_read_addr;
  logic [10*W-1:0] ram_read_data;
  logic [5:0]      head;
  logic            ret_valid;
  logic [5:0]      ret_row;
  logic [3:0]      ret_count;
  logic            exc_valid;
  logic [5:0]      exc_row;
  logic [3:0]      exc_slot;
  logic [W-1:0]    exc_data;
  logic            exc_ack;
  logic [1:0]      scan_state;

  int errors = 0;
  int checks = 0;

  logic [9:0] exp_q[$];

  logic [10*W-1:0] mem [0:47];
  logic [5:0]      rd_q;

  bob_except_retire_scan #(.DATA_WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .row_valid     (row_valid),
    .row_mask      (row_mask),
    .row_ready     (row_ready),
    .ram_read_step (ram_read_step),
    .ram_read_addr (ram_read_addr),
    .ram_read_data (ram_read_data),
    .head          (head),
    .ret_valid     (ret_valid),
    .ret_row       (ret_row),
    .ret_count     (ret_count),
    .exc_valid     (exc_valid),
    .exc_row       (exc_row),
    .exc_slot      (exc_slot),
    .exc_data      (exc_data),
    .exc_ack       (exc_ack),
    .scan_state    (scan_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- store model: address registered, data read async ------
  always @(posedge clk) begin
    if (ram_read_step) rd_q <= ram_read_addr;
  end
  assign ram_read_data = mem[rd_q];

  // Slot k word = 0xA000 | k<<4 | flag.
  function automatic logic [10*W-1:0] mk_row(input logic [9:0] fl);
    logic [10*W-1:0] r;
    r = '0;
    for (int k = 0; k < 10; k++) begin
      r[k*W +: W] = 16'hA000 | 16'(k << 4) | {15'd0, fl[k]};
    end
    return r;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_retire(input logic [5:0] row, input logic [3:0] cnt);
    exp_q.push_back({row, cnt});
  endtask

  // Scoreboard: every ret_valid pulse must match the oldest expected retire.
  always @(negedge clk) begin
    if (ret_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ret", {22'd0, ret_row, ret_count}, 32'h3FF_FFFF);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        chk("ret_row", ret_row, e[9:4]);
        chk("ret_count", ret_count, e[3:0]);
      end
    end
  end

  // ---------------- driver ----------------
  // Called at posedge+1; returns at posedge+1 of the cycle where results show.
  task automatic drive_row(input logic [9:0] m, input logic [5:0] exp_addr);
    int n;
    n = 0;
    while (!row_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!row_ready) chk("row_ready_wait", row_ready, 1);
    row_valid = 1'b1;
    row_mask  = m;
    #1;
    chk("read_step", ram_read_step, 1);
    chk("read_addr", ram_read_addr, exp_addr);
    @(posedge clk); #1;
    row_valid = 1'b0;
    row_mask  = '0;
    chk("eval_no_ret", ret_valid, 0);
    chk("eval_state", scan_state, 1);
    @(posedge clk); #1;
  endtask

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 48; i++) mem[i] = mk_row(10'h000);
    rd_q      = '0;
    rst       = 1'b0;
    flush     = 1'b0;
    row_valid = 1'b0;
    row_mask  = '0;
    exc_ack   = 1'b0;

    #12;
    chk("rst_head", head, 0);
    chk("rst_ret_valid", ret_valid, 0);
    chk("rst_exc_valid", exc_valid, 0);
    chk("rst_state", scan_state, 0);
    chk("rst_ret_count", ret_count, 0);
    chk("rst_read_step", ram_read_step, 0);
    @(negedge clk);
    rst = 1'b1;
    cycle();
    chk("post_rst_ready", row_ready, 1);

    // Empty rows walk head 0 -> 5; each retires zero slots.
    for (int i = 0; i < 5; i++) begin
      expect_retire(6'(i), 4'd0);
      drive_row(10'h000, 6'(i));
      chk("empty_head", head, 6'(i + 1));
      chk("empty_no_exc", exc_valid, 0);
    end

    // Clean full row at head 5.
    expect_retire(6'd5, 4'd10);
    drive_row(10'h3FF, 6'd5);
    chk("clean_ret_valid", ret_valid, 1);
    chk("clean_head", head, 6);
    chk("clean_no_exc", exc_valid, 0);
    cycle();
    chk("ret_pulse_one_cycle", ret_valid, 0);

    // Flag on unoccupied slot 7 is ignored.
    mem[6] = mk_row(10'h080);
    expect_retire(6'd6, 4'd4);
    drive_row(10'h00F, 6'd6);
    chk("masked_head", head, 7);
    chk("masked_no_exc", exc_valid, 0);

    // Flags on slots 3 and 6; slot 3 wins.
    mem[7] = mk_row(10'h048);
    expect_retire(6'd7, 4'd3);
    drive_row(10'h0FF, 6'd7);
    chk("exc_valid", exc_valid, 1);
    chk("exc_row", exc_row, 7);
    chk("exc_slot", exc_slot, 3);
    chk("exc_data", exc_data, 16'hA031);
    chk("exc_head_held", head, 7);
    for (int i = 0; i < 5; i++) begin
      chk("exc_hold_valid", exc_valid, 1);
      chk("exc_hold_data", exc_data, 16'hA031);
      chk("exc_hold_slot", exc_slot, 3);
      chk("report_not_ready", row_ready, 0);
      chk("report_state", scan_state, 2);
      cycle();
    end
    exc_ack = 1'b1;
    cycle();
    exc_ack = 1'b0;
    chk("ack_exc_drop", exc_valid, 0);
    chk("halt_state", scan_state, 3);
    row_valid = 1'b1;
    row_mask  = 10'h3FF;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("halt_not_ready", row_ready, 0);
      chk("halt_no_step", ram_read_step, 0);
      cycle();
    end
    row_valid = 1'b0;
    flush     = 1'b1;
    cycle();
    flush = 1'b0;
    chk("flush_halt_head", head, 0);
    chk("flush_halt_state", scan_state, 0);
    chk("flush_halt_ready", row_ready, 1);

    // Flush coinciding with row_valid: no read, head back to 0.
    expect_retire(6'd0, 4'd0);
    drive_row(10'h000, 6'd0);
    chk("pre_flush_head", head, 1);
    row_valid = 1'b1;
    row_mask  = 10'h3FF;
    flush     = 1'b1;
    #1;
    chk("flush_no_step", ram_read_step, 0);
    cycle();
    row_valid = 1'b0;
    flush     = 1'b0;
    chk("flush_rv_head", head, 0);
    chk("flush_rv_state", scan_state, 0);
    cycle();
    chk("flush_rv_no_ret", ret_valid, 0);

    // Flush during EVAL drops the in-flight row, even one with a fault.
    expect_retire(6'd0, 4'd0);
    drive_row(10'h000, 6'd0);
    mem[1] = mk_row(10'h002);
    row_valid = 1'b1;
    row_mask  = 10'h3FF;
    cycle();
    row_valid = 1'b0;
    flush     = 1'b1;
    cycle();
    flush = 1'b0;
    chk("flush_eval_no_ret", ret_valid, 0);
    chk("flush_eval_no_exc", exc_valid, 0);
    chk("flush_eval_head", head, 0);
    chk("flush_eval_state", scan_state, 0);
    cycle();
    chk("flush_eval_no_ret2", ret_valid, 0);

    // Walk to head 47 (row 1 still carries a stale flag, mask 0), then wrap.
    for (int i = 0; i < 47; i++) begin
      expect_retire(6'(i), 4'd0);
      drive_row(10'h000, 6'(i));
    end
    chk("walk_head", head, 47);
    expect_retire(6'd47, 4'd10);
    drive_row(10'h3FF, 6'd47);
    chk("wrap_head", head, 0);
    chk("wrap_no_exc", exc_valid, 0);

    // Async reset in the middle of REPORT.
    expect_retire(6'd0, 4'd0);
    drive_row(10'h000, 6'd0);
    mem[1] = mk_row(10'h002);
    expect_retire(6'd1, 4'd1);
    drive_row(10'h003, 6'd1);
    chk("r_exc_valid", exc_valid, 1);
    chk("r_exc_slot", exc_slot, 1);
    chk("r_exc_data", exc_data, 16'hA011);
    cycle();
    #2;
    rst = 1'b0;
    #1;
    chk("async_exc_drop", exc_valid, 0);
    chk("async_head", head, 0);
    chk("async_state", scan_state, 0);
    @(negedge clk);
    rst = 1'b1;
    cycle();
    chk("release_ready", row_ready, 1);
    chk("release_state", scan_state, 0);

    cycle();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
